// File: rtl/acc_drain_unit.sv
// acc_drain_unit
// Accumulates signed partial-sum beats into a saturating accumulator, then
// drains one scaled, saturated activation per vector through a valid/ready
// output handshake. Two-state FSM: ACC (taking beats) and EMIT (presenting).
module acc_drain_unit #(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  input  logic [3:0]        frac_shift,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_act,
  output logic              out_en,
  output logic              sat_flag
);

  typedef enum logic {
    ST_ACC  = 1'b0,
    ST_EMIT = 1'b1
  } state_e;

  localparam logic signed [ACC_W-1:0] ACC_MAX  = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN  = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic [DATA_W-1:0]       DATA_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0]       DATA_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  state_e                   state_q;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [3:0]               shift_q, shift_d;
  logic                     first_q;
  logic [DATA_W-1:0]        act_q, act_d;
  logic                     sat_q, sat_d;

  logic                     accept;
  logic [ACC_W:0]           beat_ext;
  logic [ACC_W:0]           sum_w;
  logic                     add_ovf;
  logic signed [ACC_W-1:0]  shifted;
  logic [ACC_W-DATA_W:0]    upper;
  logic                     out_fit;

  // Ready only in ACC and never while reset is held, so no beat can be
  // claimed as accepted during reset.
  assign in_ready  = (state_q == ST_ACC) && !rst;
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == ST_EMIT);
  assign out_en    = out_valid;
  assign out_act   = act_q;
  assign sat_flag  = sat_q;

  // Next accumulator value, latched shift, and the scaled/saturated result
  // that would be captured if this beat closes the vector.
  always_comb begin
    // NOTE: every always_comb output gets a value on every path (here by
    // straight-line assignment) so no latch is inferred.
    beat_ext = {{(ACC_W+1-DATA_W){in_data[DATA_W-1]}}, in_data};
    sum_w    = {acc_q[ACC_W-1], acc_q} + beat_ext;
    add_ovf  = sum_w[ACC_W] ^ sum_w[ACC_W-1];
    if (add_ovf) begin
      acc_d = sum_w[ACC_W] ? ACC_MIN : ACC_MAX;
    end else begin
      acc_d = sum_w[ACC_W-1:0];
    end
    // The first beat of a vector supplies the shift, including a one-beat
    // vector whose result is computed in the same cycle.
    shift_d = first_q ? frac_shift : shift_q;
    shifted = acc_d >>> shift_d;
    upper   = shifted[ACC_W-1:DATA_W-1];
    out_fit = (&upper) | (~|upper);
    if (out_fit) begin
      act_d = shifted[DATA_W-1:0];
    end else begin
      act_d = shifted[ACC_W-1] ? DATA_MIN : DATA_MAX;
    end
    sat_d = sat_q | add_ovf | (in_last & ~out_fit);
  end

  // FSM plus all datapath registers; outputs are taken straight from state.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: every register here is a small control/datapath flop (no memory
    // arrays), so all of them are cleared by the asynchronous reset.
    if (rst) begin
      state_q <= ST_ACC;
      acc_q   <= '0;
      shift_q <= '0;
      first_q <= 1'b1;
      act_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values regardless of statement order.
      case (state_q)
        ST_ACC: begin
          if (accept) begin
            acc_q   <= acc_d;
            shift_q <= shift_d;
            first_q <= in_last;
            sat_q   <= sat_d;
            if (in_last) begin
              act_q   <= act_d;
              state_q <= ST_EMIT;
            end
          end
        end
        ST_EMIT: begin
          if (out_ready) begin
            acc_q   <= '0;
            sat_q   <= 1'b0;
            state_q <= ST_ACC;
          end
        end
        default: state_q <= ST_ACC;
      endcase
    end
  end

endmodule

// File: tb/tb_acc_drain_unit.sv
// Directed bench for acc_drain_unit. A second instance with a narrow
// accumulator shares all inputs so accumulator saturation is reachable
// within a few beats; both instances move in lockstep.
module tb_acc_drain_unit;

  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          in_last;
  logic [3:0]    frac_shift;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_act;
  logic          out_en;
  logic          sat_flag;

  logic          n_in_ready;
  logic          n_out_valid;
  logic [DW-1:0] n_out_act;
  logic          n_out_en;
  logic          n_sat_flag;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  acc_drain_unit #(.DATA_W(DW), .ACC_W(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .frac_shift(frac_shift),
    .out_valid(out_valid), .out_ready(out_ready), .out_act(out_act),
    .out_en(out_en), .sat_flag(sat_flag)
  );

  acc_drain_unit #(.DATA_W(DW), .ACC_W(18)) dut_narrow (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(n_in_ready), .in_data(in_data),
    .in_last(in_last), .frac_shift(frac_shift),
    .out_valid(n_out_valid), .out_ready(out_ready), .out_act(n_out_act),
    .out_en(n_out_en), .sat_flag(n_sat_flag)
  );

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One accepted beat: inputs driven 1 time unit after an edge, released
  // 1 time unit after the capturing edge.
  task automatic send(input logic signed [DW-1:0] data, input logic last,
                      input logic [3:0] shift);
    in_valid   = 1'b1;
    in_data    = data;
    in_last    = last;
    frac_shift = shift;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic take();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_data    = '0;
    in_last    = 1'b0;
    frac_shift = '0;
    out_ready  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_en", out_en, 0);
    check("rst_out_act", $signed(out_act), 0);
    check("rst_sat", sat_flag, 0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", in_ready, 1);

    // 100 - 30 + 5 = 75, presented one cycle after the last beat
    send(100, 1'b0, 4'd0);
    send(-30, 1'b0, 4'd0);
    check("basic_not_yet_valid", out_valid, 0);
    send(5, 1'b1, 4'd0);
    check("basic_valid", out_valid, 1);
    check("basic_en", out_en, 1);
    check("basic_act", $signed(out_act), 75);
    check("basic_sat", sat_flag, 0);
    check("basic_in_ready_emit", in_ready, 0);
    take();
    check("basic_taken_valid", out_valid, 0);
    check("basic_taken_ready", in_ready, 1);

    // 4000 >>> 2 = 1000
    for (int i = 0; i < 4; i++) send(1000, (i == 3), 4'd2);
    check("shift2_act", $signed(out_act), 1000);
    take();
    // -7 >>> 1 = -4 (floor)
    send(-7, 1'b1, 4'd1);
    check("neg_floor_act", $signed(out_act), -4);
    check("neg_floor_sat", sat_flag, 0);
    take();

    // 60000 exceeds DATA_W range
    send(30000, 1'b0, 4'd0);
    send(30000, 1'b1, 4'd0);
    check("outsat_act", $signed(out_act), 32767);
    check("outsat_flag", sat_flag, 1);
    take();
    send(1, 1'b1, 4'd0);
    check("after_sat_act", $signed(out_act), 1);
    check("after_sat_flag", sat_flag, 0);
    take();

    // 5 x 30000: wide acc 150000>>>2=37500 -> 32767; narrow acc clips at 131071
    for (int i = 0; i < 5; i++) send(30000, (i == 4), 4'd2);
    check("wide_pos_act", $signed(out_act), 32767);
    check("wide_pos_sat", sat_flag, 1);
    check("narrow_valid", n_out_valid, 1);
    check("narrow_pos_act", $signed(n_out_act), 32767);
    check("narrow_pos_sat", n_sat_flag, 1);
    take();
    // 5 x -32768: narrow clips at -131072 -> -32768 after shift
    for (int i = 0; i < 5; i++) send(-32768, (i == 4), 4'd2);
    check("wide_neg_act", $signed(out_act), -32768);
    check("narrow_neg_act", $signed(n_out_act), -32768);
    check("narrow_neg_sat", n_sat_flag, 1);
    take();
    // 4 x 30000 = 120000 fits the narrow acc: no saturation anywhere
    for (int i = 0; i < 4; i++) send(30000, (i == 3), 4'd2);
    check("narrow_fit_act", $signed(n_out_act), 30000);
    check("narrow_fit_sat", n_sat_flag, 0);
    check("wide_fit_act", $signed(out_act), 30000);
    take();
    check("narrow_ready", n_in_ready, 1);

    // Backpressure: output held, offered beat refused until release
    send(42, 1'b1, 4'd0);
    in_valid   = 1'b1;
    in_data    = 16'd7;
    in_last    = 1'b1;
    frac_shift = 4'd0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("hold_act", $signed(out_act), 42);
      check("hold_in_ready", in_ready, 0);
      check("hold_valid", out_valid, 1);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("release_valid", out_valid, 0);
    check("release_ready", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    check("held_beat_valid", out_valid, 1);
    check("held_beat_act", $signed(out_act), 7);
    take();

    // Reset mid-vector discards the partial sum
    send(5, 1'b0, 4'd0);
    send(6, 1'b0, 4'd0);
    rst = 1'b1;
    #1;
    check("midrst_act", $signed(out_act), 0);
    check("midrst_valid", out_valid, 0);
    check("midrst_ready", in_ready, 0);
    check("midrst_sat", sat_flag, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("midrst_ready_after", in_ready, 1);
    send(9, 1'b1, 4'd0);
    check("midrst_fresh_act", $signed(out_act), 9);
    take();

    // Reset during EMIT drops the pending output and its accumulator
    send(3, 1'b1, 4'd0);
    check("emitrst_pre_valid", out_valid, 1);
    rst = 1'b1;
    #1;
    check("emitrst_valid", out_valid, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    send(4, 1'b1, 4'd0);
    check("emitrst_fresh_act", $signed(out_act), 4);
    take();

    // Shift latched on first beat: mid-vector change ignored
    send(8, 1'b0, 4'd0);
    send(8, 1'b1, 4'd3);
    check("latch_shift_act", $signed(out_act), 16);
    take();
    // One-beat vector uses its own shift
    send(64, 1'b1, 4'd3);
    check("one_beat_shift_act", $signed(out_act), 8);
    take();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
